// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch stage: FSM encoding, reset/NOP
// defaults and word-address helpers.
package cpu_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] WORD_STEP    = 32'd4;

  // Force a byte address onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'd3;
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus: single-outstanding req/gnt
// handshake followed by an rvalid/rdata response.
interface if_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr,
                  input imem_gnt, input imem_rvalid, input imem_rdata);
  modport slave  (input imem_req, input imem_addr,
                  output imem_gnt, output imem_rvalid, output imem_rdata);
endinterface

// File: rtl/if_inst_buf.sv
// Single-entry instruction holding register between fetch and decode.
// Flush beats load, load beats consume; an empty entry shows 0 / NOP_INST.
module if_inst_buf
  import cpu_pkg::*;
#(
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        i_load,
  input  logic [31:0] i_pc4,
  input  logic [31:0] i_inst,
  input  logic        i_consume,
  input  logic        i_flush,
  output logic        o_valid,
  output logic [31:0] o_pc4,
  output logic [31:0] o_inst
);

  logic        r_valid;
  logic [31:0] r_pc4;
  logic [31:0] r_inst;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_valid <= 1'b0;
      r_pc4   <= '0;
      r_inst  <= NOP_INST;
    end else if (i_flush || (i_consume && !i_load)) begin
      r_valid <= 1'b0;
      r_pc4   <= '0;
      r_inst  <= NOP_INST;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc4   <= i_pc4;
      r_inst  <= i_inst;
    end
  end

  assign o_valid = r_valid;
  assign o_pc4   = r_pc4;
  assign o_inst  = r_inst;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one outstanding imem request
// and buffers the reply for ID. Optional counters under IF_FETCH_PERF_EN.
module if_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic                   clk,
  input  logic                   clrn,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  if_fetch_unit_if.master        imem,
  output logic [31:0]            if_pc4,
  output logic [31:0]            if_inst,
  output logic                   if_valid
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0]            fetch_cnt,
  output logic [31:0]            drop_cnt
`endif
);

  fetch_state_e r_state;
  fetch_state_e w_state_next;
  logic [31:0]  r_pc;
  logic [31:0]  r_inflight_pc4;
  logic [31:0]  w_pc_plus4;
  logic         w_consume;
  logic         w_accept;
  logic         w_load;

  assign w_pc_plus4 = r_pc + WORD_STEP;
  assign w_consume  = if_valid & ~stall;
  assign w_accept   = imem.imem_req & imem.imem_gnt;
  // A redirect in the response cycle turns the reply into wrong-path data.
  assign w_load     = (r_state == WAIT) & imem.imem_rvalid & ~redirect;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) r_state <= FETCH;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      FETCH:   if (w_accept) w_state_next = redirect ? DROP : WAIT;
      WAIT: begin
        if (imem.imem_rvalid) w_state_next = FETCH;
        else if (redirect)    w_state_next = DROP;
      end
      DROP:    if (imem.imem_rvalid) w_state_next = FETCH;
      default: w_state_next = FETCH;
    endcase
  end

  // Requests only go out when the reply is guaranteed a free buffer slot.
  always_comb begin
    imem.imem_req  = 1'b0;
    imem.imem_addr = r_pc;
    if (r_state == FETCH) imem.imem_req = clrn & (~if_valid | w_consume);
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_pc           <= RESET_PC;
      r_inflight_pc4 <= '0;
    end else begin
      if (redirect)      r_pc <= word_align(redirect_pc);
      else if (w_accept) r_pc <= w_pc_plus4;
      if (w_accept) r_inflight_pc4 <= w_pc_plus4;
    end
  end

  if_inst_buf #(.NOP_INST(NOP_INST)) u_buf (
    .clk       (clk),
    .clrn      (clrn),
    .i_load    (w_load),
    .i_pc4     (r_inflight_pc4),
    .i_inst    (imem.imem_rdata),
    .i_consume (w_consume),
    .i_flush   (redirect),
    .o_valid   (if_valid),
    .o_pc4     (if_pc4),
    .o_inst    (if_inst)
  );

`ifdef IF_FETCH_PERF_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_drop_cnt;
  logic        w_discard;

  assign w_discard = imem.imem_rvalid &
                     ((r_state == DROP) | ((r_state == WAIT) & redirect));

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_fetch_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (w_consume) r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (w_discard) r_drop_cnt  <= r_drop_cnt + 32'd1;
    end
  end

  assign fetch_cnt = r_fetch_cnt;
  assign drop_cnt  = r_drop_cnt;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: stimulus queues expected request
// addresses and consumed instructions; memory and consume monitors check them.
module tb_if_fetch_unit;
  import cpu_pkg::*;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] inst;
  } fetch_t;

  logic        clk = 1'b0;
  logic        clrn;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] if_pc4;
  logic [31:0] if_inst;
  logic        if_valid;
`ifdef IF_FETCH_PERF_EN
  logic [31:0] fetch_cnt;
  logic [31:0] drop_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int gnt_until = 0;
  int rv_extra = 0;

  fetch_t      data_q[$];
  logic [31:0] addr_q[$];

  if_fetch_unit_if bus();

  if_fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INST(32'h0000_0000)) dut (
    .clk         (clk),
    .clrn        (clrn),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (bus.master),
    .if_pc4      (if_pc4),
    .if_inst     (if_inst),
    .if_valid    (if_valid)
`ifdef IF_FETCH_PERF_EN
    ,
    .fetch_cnt   (fetch_cnt),
    .drop_cnt    (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'h2001_0005;
      32'h0000_0004: mem_word = 32'h2002_0007;
      32'h0000_0008: mem_word = 32'h0022_1820;
      32'h0000_000C: mem_word = 32'h8C01_0004;
      32'h0000_0100: mem_word = 32'hAC03_0010;
      default:       mem_word = {16'hDEAD, a[15:0]};
    endcase
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end else begin
      $display("ok   %s: %b", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Wait (bounded) for the buffer to fill, then check what it holds.
  task automatic wait_loaded(input string name, input logic [31:0] pc4, input logic [31:0] inst);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = if_valid;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_valid: timeout, if_valid got 0 required 1", name);
    end
    check32({name, "_pc4"}, if_pc4, pc4);
    check32({name, "_inst"}, if_inst, inst);
  endtask

  // Memory model: checks each granted address, replies after 1+rv_extra cycles.
  initial begin : mem_model
    logic        acc;
    logic [31:0] acc_addr;
    logic        pend;
    logic [31:0] paddr;
    int          cnt;
    pend = 1'b0;
    paddr = '0;
    cnt = 0;
    bus.imem_gnt = 1'b1;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = '0;
    forever begin
      @(posedge clk);
      cyc++;
      acc = clrn & bus.imem_req & bus.imem_gnt;
      acc_addr = bus.imem_addr;
      if (acc) begin
        if (addr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL req_addr: unexpected request at %h, none required", acc_addr);
        end else begin
          check32("req_addr", acc_addr, addr_q.pop_front());
        end
      end
      #1;
      bus.imem_rvalid = 1'b0;
      if (!clrn) pend = 1'b0;
      if (acc) begin
        pend = 1'b1;
        paddr = acc_addr;
        cnt = rv_extra;
      end
      if (pend) begin
        if (cnt == 0) begin
          bus.imem_rvalid = 1'b1;
          bus.imem_rdata = mem_word(paddr);
          pend = 1'b0;
        end else begin
          cnt--;
        end
      end
      bus.imem_gnt = (cyc >= gnt_until);
    end
  end

  initial begin : consume_mon
    fetch_t e;
    forever begin
      @(negedge clk);
      if (clrn && if_valid && !stall) begin
        if (data_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL consume: unexpected pc4 %h inst %h, none required", if_pc4, if_inst);
        end else begin
          e = data_q.pop_front();
          check32("consume_pc4", if_pc4, e.pc4);
          check32("consume_inst", if_inst, e.inst);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    clrn = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;

    repeat (2) @(negedge clk);
    check1("rst_valid", if_valid, 1'b0);
    check32("rst_pc4", if_pc4, 32'h0);
    check32("rst_inst", if_inst, 32'h0);
    check1("rst_req", bus.imem_req, 1'b0);

    // Free-running fetch of three instructions, then park on the fourth.
    addr_q.push_back(32'h0);
    addr_q.push_back(32'h4);
    addr_q.push_back(32'h8);
    addr_q.push_back(32'hC);
    data_q.push_back(fetch_t'{32'h4, 32'h2001_0005});
    data_q.push_back(fetch_t'{32'h8, 32'h2002_0007});
    data_q.push_back(fetch_t'{32'hC, 32'h0022_1820});
    step();
    clrn = 1'b1;
    for (int i = 0; i < 40 && data_q.size() != 0; i++) step();
    checks++;
    if (data_q.size() != 0) begin
      errors++;
      $display("FAIL stream: %0d instructions never consumed, required 0", data_q.size());
    end
    stall = 1'b1;
    wait_loaded("park", 32'h10, 32'h8C01_0004);

    // Stall holds the buffer and blocks requests.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check32("stall_inst", if_inst, 32'h8C01_0004);
      check32("stall_pc4", if_pc4, 32'h10);
      check1("stall_req", bus.imem_req, 1'b0);
    end
    data_q.push_back(fetch_t'{32'h10, 32'h8C01_0004});
    addr_q.push_back(32'h10);
    step();
    stall = 1'b0;
    @(negedge clk);
    check1("resume_req", bus.imem_req, 1'b1);
    check32("resume_addr", bus.imem_addr, 32'h10);
    step();
    stall = 1'b1;
    wait_loaded("resume", 32'h14, 32'hDEAD_0010);

    // Redirect while waiting on a slow reply: the reply must be dropped.
    rv_extra = 2;
    data_q.push_back(fetch_t'{32'h14, 32'hDEAD_0010});
    addr_q.push_back(32'h14);
    addr_q.push_back(32'h100);
    step();
    stall = 1'b0;
    step();
    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    @(negedge clk);
    check1("wait_req", bus.imem_req, 1'b0);
    step();
    redirect = 1'b0;
    stall = 1'b1;
    rv_extra = 0;
    @(negedge clk);
    check1("drop_valid", if_valid, 1'b0);
    check1("drop_req", bus.imem_req, 1'b0);
    wait_loaded("redirect", 32'h104, 32'hAC03_0010);

    // Redirect and stall together with a full buffer: redirect wins.
    addr_q.push_back(32'h200);
    step();
    redirect = 1'b1;
    redirect_pc = 32'h0000_0200;
    @(negedge clk);
    check32("preflush_pc4", if_pc4, 32'h104);
    step();
    redirect = 1'b0;
    @(negedge clk);
    check1("flush_valid", if_valid, 1'b0);
    check32("flush_inst", if_inst, 32'h0);
    check1("flush_req", bus.imem_req, 1'b1);
    check32("flush_addr", bus.imem_addr, 32'h200);
    wait_loaded("restart", 32'h204, 32'hDEAD_0200);

    // Grant withheld for four request cycles.
    data_q.push_back(fetch_t'{32'h204, 32'hDEAD_0200});
    addr_q.push_back(32'h204);
    step();
    gnt_until = cyc + 5;
    step();
    stall = 1'b0;
    @(negedge clk);
    check1("nognt_req", bus.imem_req, 1'b1);
    check32("nognt_addr", bus.imem_addr, 32'h204);
    step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check1("nognt_req", bus.imem_req, 1'b1);
      check32("nognt_addr", bus.imem_addr, 32'h204);
    end
    wait_loaded("late_gnt", 32'h208, 32'hDEAD_0204);

    // Asynchronous reset while waiting on a reply.
    data_q.push_back(fetch_t'{32'h208, 32'hDEAD_0204});
    addr_q.push_back(32'h208);
    step();
    stall = 1'b0;
    step();
    stall = 1'b1;
    clrn = 1'b0;
    #1;
    check1("arst_valid", if_valid, 1'b0);
    check32("arst_pc4", if_pc4, 32'h0);
    check32("arst_inst", if_inst, 32'h0);
    check1("arst_req", bus.imem_req, 1'b0);
    check32("arst_addr", bus.imem_addr, 32'h0);
    addr_q.push_back(32'h0);
    step();
    clrn = 1'b1;
    @(negedge clk);
    check1("post_rst_req", bus.imem_req, 1'b1);
    check32("post_rst_addr", bus.imem_addr, 32'h0);
    wait_loaded("post_rst", 32'h4, 32'h2001_0005);

    repeat (2) @(negedge clk);
    checks++;
    if (data_q.size() != 0 || addr_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: data %0d addr %0d outstanding, required 0 0",
               data_q.size(), addr_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage pipelined CPU. It is the producer side of the IF/ID interface.
- Owns the PC and issues single-outstanding requests to instruction memory.
- Buffers one returned instruction and presents it to the IF/ID pipeline register as if_pc4/if_inst/if_valid.
- Honours hazard stalls from ID and branch/jump redirects, discarding wrong-path fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset; low 2 bits must be 0.
- NOP_INST, 32'h0000_0000, value driven on if_inst when no valid instruction is buffered.

Ports:
- clk  in  1  pipeline clock, rising edge.
- clrn  in  1  asynchronous active-low reset.
- stall  in  1  ID hazard hold; the buffered instruction is not consumed this cycle.
- redirect  in  1  branch/jump taken; fetch restarts at redirect_pc.
- redirect_pc  in  32  new fetch address; bits [1:0] ignored and treated as 0.
- imem_req  out  1  request valid to instruction memory.
- imem_addr  out  32  request word address (current PC).
- imem_gnt  in  1  memory accepts the request this cycle (handshake with imem_req).
- imem_rvalid  in  1  read data valid; never in the same cycle as its own gnt.
- imem_rdata  in  32  instruction word.
- if_pc4  out  32  PC+4 of the buffered instruction.
- if_inst  out  32  buffered instruction.
- if_valid  out  1  buffer holds a valid instruction.

Behaviour:
- Reset (clrn=0, asynchronous):
  - pc=RESET_PC; buffer empty.
  - if_valid=0, if_pc4=0, if_inst=NOP_INST, imem_req=0.
  - inflight_pc4=0; state FETCH.
- Consume: consume = if_valid & ~stall. The buffer empties on consume unless refilled the same cycle.
- States:
  - FETCH: imem_req = ~buf_full | consume; imem_addr = pc.
    - On req & gnt: inflight_pc4 <= pc+4; pc <= pc+4; go to WAIT.
    - With no gnt, hold imem_addr stable while imem_req=1.
  - WAIT: imem_req=0.
    - On rvalid: buffer <= {inflight_pc4, imem_rdata}, if_valid <= 1, go to FETCH.
    - Request-gating guarantees the buffer is empty when rvalid arrives.
  - DROP: imem_req=0.
    - On rvalid: discard data, go to FETCH.
- Latency: at least 2 cycles from imem_req to if_valid (gnt cycle, then rvalid cycle registers into the buffer). Throughput is one instruction per 2 cycles with a 1-cycle memory.
- Redirect (highest priority, over stall and rvalid):
  - pc <= {redirect_pc[31:2], 2'b00}; buffer cleared (if_valid <= 0, outputs return to 0/NOP_INST).
  - State update on redirect:
    - FETCH with gnt the same cycle → DROP; the granted request is not counted.
    - FETCH without gnt → stay FETCH; the request with the new pc is issued next cycle.
    - WAIT without rvalid → DROP.
    - WAIT with rvalid the same cycle → data dropped, go to FETCH.
    - DROP → stay DROP.
- Stall: the buffer holds its contents and outputs stay stable. No new request is issued while the buffer is full and not consumed. An in-flight response is still accepted, because the buffer was empty at issue.
- PC arithmetic: 32-bit, wraps from 32'hFFFF_FFFC to 0 silently.
- Reset mid-operation: any in-flight response is lost. Memory must tolerate an abandoned request.

Optional Feature:
- Macro IF_FETCH_PERF_EN.
- When defined:
  - Adds output port fetch_cnt (32) counting consumed instructions.
  - Adds output port drop_cnt (32) counting discarded responses.
  - Both counters reset to 0 and wrap.
- When undefined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package cpu_pkg:
  - state encoding (FETCH=2'd0, WAIT=2'd1, DROP=2'd2);
  - NOP_INST default;
  - RESET_PC default;
  - word-step constant 32'd4.
- One natural sub-module: if_inst_buf (single-entry holding register with load/consume/flush, driving if_valid/if_pc4/if_inst).

Test Plan:
- Reset then release, memory gnt immediately and rvalid 1 cycle later, stall=0 → imem_addr sequence 0x0,0x4,0x8, and if_pc4 0x4,0x8,0xC with the matching imem_rdata.
- stall=1 for 3 cycles while if_valid=1 holding inst 0x8C010004 → if_inst/if_pc4 stable, imem_req=0 throughout, fetch resumes the cycle after stall drops.
- redirect=1 with redirect_pc=0x0000_0103 while in WAIT → if_valid=0 next cycle, the late rvalid data is not presented, next imem_addr=0x100, next if_pc4=0x104.
- redirect and stall asserted the same cycle with the buffer full → buffer flushed and fetch restarts at redirect_pc (redirect wins).
- imem_gnt held low for 4 cycles → imem_req stays 1 with imem_addr constant; then gnt → normal completion.
- clrn pulsed low during WAIT → all outputs return to reset values asynchronously, and the first request after release is RESET_PC.
